// File: rtl/alu_cu.sv
// Control unit for the 8-bit sequential ALU: sequences add, subtract, Booth
// multiply and non-restoring divide by strobing the A/Q/M/Q_1/COUNT datapath.
module alu_cu (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BGN,
  input  logic [1:0] OP,
  input  logic       Q0,
  input  logic       Q_1,
  input  logic       A7,
  input  logic       CNT7,
  output logic       c0,
  output logic       c0_prim,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic       cR,
  output logic       cL,
  output logic       c5,
  output logic       c6,
  output logic       c7,
  output logic       c7_5,
  output logic       c8
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LD1   = 4'd1,
    S_LD2   = 4'd2,
    S_AS    = 4'd3,
    S_MTEST = 4'd4,
    S_MADD  = 4'd5,
    S_MSUB  = 4'd6,
    S_MSH   = 4'd7,
    S_DSH   = 4'd8,
    S_DSUB  = 4'd9,
    S_DADD  = 4'd10,
    S_DQ    = 4'd11,
    S_DCORR = 4'd12,
    S_OUT1  = 4'd13,
    S_OUT2  = 4'd14,
    S_DONE  = 4'd15
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;

  // State and latched operation code
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; OP is only looked at in LD2, later flow uses op_q
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE:  state_d = BGN ? S_LD1 : S_IDLE;
      S_LD1:   state_d = S_LD2;
      S_LD2: begin
        op_d = OP;
        case (OP)
          2'b10:   state_d = S_MTEST;
          2'b11:   state_d = S_DSH;
          default: state_d = S_AS;
        endcase
      end
      S_AS:    state_d = S_OUT1;
      S_MTEST: begin
        case ({Q0, Q_1})
          2'b01:   state_d = S_MADD;
          2'b10:   state_d = S_MSUB;
          default: state_d = S_MSH;
        endcase
      end
      S_MADD:  state_d = S_MSH;
      S_MSUB:  state_d = S_MSH;
      S_MSH:   state_d = CNT7 ? S_OUT1 : S_MTEST;
      S_DSH:   state_d = A7 ? S_DADD : S_DSUB;
      S_DSUB:  state_d = S_DQ;
      S_DADD:  state_d = S_DQ;
      S_DQ: begin
        if (!CNT7)   state_d = S_DSH;
        else if (A7) state_d = S_DCORR;
        else         state_d = S_OUT1;
      end
      S_DCORR: state_d = S_OUT1;
      S_OUT1:  state_d = op_q[1] ? S_OUT2 : S_DONE;
      S_OUT2:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore strobe decode; c5 reads the post-add/sub sign live in DQ
  always_comb begin
    c0      = 1'b0;
    c0_prim = 1'b0;
    c1      = 1'b0;
    c2      = 1'b0;
    c3      = 1'b0;
    c4      = 1'b0;
    cR      = 1'b0;
    cL      = 1'b0;
    c5      = 1'b0;
    c6      = 1'b0;
    c7      = 1'b0;
    c7_5    = 1'b0;
    c8      = 1'b0;
    case (state_q)
      S_LD1:   c0 = 1'b1;
      S_LD2:   c0_prim = 1'b1;
      S_AS: begin
        c1 = 1'b1;
        c3 = 1'b1;
        c2 = op_q[0];
      end
      S_MADD:  c1 = 1'b1;
      S_MSUB: begin
        c1 = 1'b1;
        c2 = 1'b1;
      end
      S_MSH: begin
        cR = 1'b1;
        c4 = 1'b1;
      end
      S_DSH:   cL = 1'b1;
      S_DSUB: begin
        c1 = 1'b1;
        c2 = 1'b1;
      end
      S_DADD:  c1 = 1'b1;
      S_DQ: begin
        c4 = 1'b1;
        c5 = ~A7;
      end
      S_DCORR: c7_5 = 1'b1;
      S_OUT1:  c6 = 1'b1;
      S_OUT2:  c7 = 1'b1;
      S_DONE:  c8 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_cu.sv
// Bench for alu_cu: builds the expected per-cycle strobe trace of each
// operation from the operation rules and compares the DUT against it.
module tb_alu_cu;

  logic       CLK = 1'b0;
  logic       RST, BGN, Q0, Q_1, A7, CNT7;
  logic [1:0] OP;
  logic       c0, c0_prim, c1, c2, c3, c4, cR, cL, c5, c6, c7, c7_5, c8;

  alu_cu dut (
    .CLK(CLK), .RST(RST), .BGN(BGN), .OP(OP),
    .Q0(Q0), .Q_1(Q_1), .A7(A7), .CNT7(CNT7),
    .c0(c0), .c0_prim(c0_prim), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .cR(cR), .cL(cL), .c5(c5), .c6(c6), .c7(c7), .c7_5(c7_5), .c8(c8)
  );

  always #5 CLK = ~CLK;

  localparam logic [12:0] C0  = 13'h1000;
  localparam logic [12:0] C0P = 13'h0800;
  localparam logic [12:0] C1  = 13'h0400;
  localparam logic [12:0] C2  = 13'h0200;
  localparam logic [12:0] C3  = 13'h0100;
  localparam logic [12:0] C4  = 13'h0080;
  localparam logic [12:0] CR  = 13'h0040;
  localparam logic [12:0] CL  = 13'h0020;
  localparam logic [12:0] C5  = 13'h0010;
  localparam logic [12:0] C6  = 13'h0008;
  localparam logic [12:0] C7  = 13'h0004;
  localparam logic [12:0] C75 = 13'h0002;
  localparam logic [12:0] C8  = 13'h0001;

  typedef struct {
    logic        rst;
    logic        bgn;
    logic [1:0]  op;
    logic        q0;
    logic        q_1;
    logic        a7;
    logic        cnt7;
    logic [12:0] exp;
  } ent_t;

  ent_t       tq[$];
  ent_t       sq[$];
  logic [1:0] mp [8];
  logic       dsa [8];
  logic       dqa [8];
  int         ld1_idx;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         lat = -1;

  wire [12:0] got = {c0, c0_prim, c1, c2, c3, c4, cR, cL, c5, c6, c7, c7_5, c8};

  // Entry with every input the state ignores randomised
  function automatic ent_t mk(input logic [12:0] exp);
    ent_t e;
    e.rst  = 1'b0;
    e.bgn  = 1'($urandom);
    e.op   = 2'($urandom);
    e.q0   = 1'($urandom);
    e.q_1  = 1'($urandom);
    e.a7   = 1'($urandom);
    e.cnt7 = 1'($urandom);
    e.exp  = exp;
    return e;
  endfunction

  task automatic put(input ent_t e, input logic [1:0] op, input bit scr);
    if (!scr) e.op = op;
    tq.push_back(e);
  endtask

  // Expected trace of one operation, starting with the IDLE cycle that sees BGN
  task automatic build(input logic [1:0] op, input int gap, input bit scr);
    ent_t e;
    tq.delete();
    for (int i = 0; i < gap; i++) begin
      e = mk(13'h0); e.bgn = 1'b0; tq.push_back(e);
    end
    e = mk(13'h0); e.bgn = 1'b1; tq.push_back(e);
    ld1_idx = tq.size();
    tq.push_back(mk(C0));
    e = mk(C0P); e.op = op; tq.push_back(e);
    if (op[1] == 1'b0) begin
      put(mk(C1 | C3 | (op[0] ? C2 : 13'h0)), op, scr);
    end else if (op == 2'b10) begin
      for (int i = 0; i < 8; i++) begin
        e = mk(13'h0); e.q0 = mp[i][1]; e.q_1 = mp[i][0]; put(e, op, scr);
        if (mp[i] == 2'b01) put(mk(C1), op, scr);
        else if (mp[i] == 2'b10) put(mk(C1 | C2), op, scr);
        e = mk(CR | C4); e.cnt7 = (i == 7); put(e, op, scr);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = mk(CL); e.a7 = dsa[i]; put(e, op, scr);
        put(mk(dsa[i] ? C1 : (C1 | C2)), op, scr);
        e = mk(C4 | (dqa[i] ? 13'h0 : C5)); e.a7 = dqa[i]; e.cnt7 = (i == 7);
        put(e, op, scr);
        if (i == 7 && dqa[i]) put(mk(C75), op, scr);
      end
    end
    put(mk(C6), op, scr);
    if (op[1]) put(mk(C7), op, scr);
    put(mk(C8), op, scr);
  endtask

  task automatic abort_at(input int k);
    tq[k].rst = 1'b1;
    tq[k].bgn = 1'b1;
    while (tq.size() > k + 1) tq.delete(tq.size() - 1);
  endtask

  task automatic commit();
    foreach (tq[i]) sq.push_back(tq[i]);
    tq.delete();
  endtask

  task automatic rnd_arrays();
    for (int i = 0; i < 8; i++) begin
      mp[i]  = 2'($urandom);
      dsa[i] = 1'($urandom);
      dqa[i] = 1'($urandom);
    end
  endtask

  // Drive each expected cycle, then compare the strobes once inputs settle
  task automatic run();
    ent_t e;
    while (sq.size() > 0) begin
      e    = sq.pop_front();
      RST  = e.rst;
      BGN  = e.bgn;
      OP   = e.op;
      Q0   = e.q0;
      Q_1  = e.q_1;
      A7   = e.a7;
      CNT7 = e.cnt7;
      #1;
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL strobes cyc=%0d got=%b want=%b", cyc, got, e.exp);
      end
      if (got[12] === 1'b1) start_cyc = cyc;
      if (got[0] === 1'b1) lat = cyc - start_cyc + 1;
      cyc++;
      @(negedge CLK);
    end
  endtask

  task automatic check_lat(input string name, input int want);
    total++;
    if (lat != want) begin
      bad++;
      $display("FAIL latency_%s got=%0d want=%0d", name, lat, want);
    end
    lat = -1;
  endtask

  initial begin
    int k, n;
    RST = 1'b1; BGN = 1'b1; OP = 2'b00;
    Q0 = 1'b0; Q_1 = 1'b0; A7 = 1'b0; CNT7 = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    total++;
    if (got !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", got, 13'h0);
    end

    rnd_arrays();
    build(2'b00, 0, 1'b0); commit(); run(); check_lat("add", 5);
    build(2'b01, 1, 1'b0); commit(); run(); check_lat("sub", 5);

    mp[0] = 2'b01; mp[1] = 2'b10; mp[2] = 2'b00; mp[3] = 2'b11;
    mp[4] = 2'b00; mp[5] = 2'b11; mp[6] = 2'b00; mp[7] = 2'b00;
    build(2'b10, 0, 1'b0); commit(); run(); check_lat("mul", 23);

    for (int i = 0; i < 8; i++) begin
      dsa[i] = 1'(i % 2);
      dqa[i] = 1'((i + 1) % 2);
    end
    dsa[0] = 1'b0; dqa[0] = 1'b1; dqa[7] = 1'b1;
    build(2'b11, 2, 1'b0); commit(); run(); check_lat("div_corr", 30);
    dqa[7] = 1'b0;
    build(2'b11, 0, 1'b1); commit(); run(); check_lat("div_nocorr", 29);

    // Reset in the third MSH of a multiply, BGN held so it restarts
    rnd_arrays();
    build(2'b10, 0, 1'b0);
    n = 0; k = -1;
    foreach (tq[i]) if (tq[i].exp == (CR | C4)) begin
      n++;
      if (n == 3 && k < 0) k = i;
    end
    abort_at(k); commit();
    build(2'b00, 0, 1'b0); commit(); run(); check_lat("add_after_abort", 5);

    for (int t = 0; t < 150; t++) begin
      rnd_arrays();
      build(2'($urandom), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 9) == 0) abort_at($urandom_range(ld1_idx, tq.size() - 1));
      commit();
    end
    for (int i = 0; i < 3; i++) begin
      tq.push_back(mk(13'h0));
      tq[tq.size() - 1].bgn = 1'b0;
    end
    commit(); run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
